// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port 64-bit unified memory between the instruction-fetch
// path and the load/store path of the core. A small three-state sequencer
// (IDLE -> BUSY -> RESP) issues one fixed-latency memory transaction at a
// time. Data accesses win arbitration by default; a starvation counter
// forces a fetch grant after STARVE_LIMIT consecutive data grants taken
// while fetch was waiting. The stall output freezes the core while any of
// its requests is outstanding.
//
// Parameters
//   MEM_LATENCY   cycles from mem_req to valid mem_rdata (1..15)
//   STARVE_LIMIT  consecutive data grants with fetch pending before fetch
//                 is forced to win (1..15)
//
// Ports
//   clk, reset           clock; asynchronous active-low reset
//   if_req/if_addr       fetch request (level) and byte address
//   if_gnt/if_valid      fetch grant pulse / response pulse
//   if_rdata             fetched 32-bit instruction word
//   dm_req/dm_we         data request (level), 1 = store
//   dm_addr/dm_wdata     data byte address and store data
//   dm_gnt/dm_valid      data grant pulse / completion pulse
//   dm_rdata             64-bit load data
//   mem_req/mem_we       memory command strobe and write enable
//   mem_addr/mem_wdata   doubleword-aligned address and write data
//   mem_rdata            memory read data, valid MEM_LATENCY after mem_req
//   stall                core hold while an access is outstanding
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [63:0] dm_addr,
    input  logic [63:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_valid,
    output logic [63:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    output logic        stall
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    localparam logic [3:0] LAT_LOAD   = 4'(MEM_LATENCY - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic        store_q, store_d;
    logic        hi_word_q, hi_word_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  starve_q, starve_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [63:0] dm_rdata_q, dm_rdata_d;

    logic        grant_if;
    logic        grant_dm;

    // Sub-doubleword address bits never reach memory; the core handles them.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], dm_addr[2:0]};

    // Arbitration. Grants are only made from IDLE and are suppressed while
    // reset is asserted so no command escapes during reset. Fetch wins when
    // data is idle or when the starvation counter has hit its limit.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (reset && (state_q == ST_IDLE)) begin
            if (if_req && (!dm_req || (starve_q == STARVE_MAX))) begin
                grant_if = 1'b1;
            end else if (dm_req) begin
                grant_dm = 1'b1;
            end
        end
    end

    // Starvation counter: counts data grants taken while fetch is waiting.
    // Any fetch grant, or any cycle without a fetch request, clears it.
    always_comb begin
        starve_d = starve_q;
        if (!if_req || grant_if) begin
            starve_d = 4'd0;
        end else if (grant_dm && (starve_q != 4'hF)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Transaction sequencer. The counter is loaded with MEM_LATENCY-1 at
    // grant so that it reads zero in exactly the cycle mem_rdata is valid.
    // The fetch word select is latched at grant so the response does not
    // depend on the requester still holding its address.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        store_d    = store_q;
        hi_word_d  = hi_word_q;
        cnt_d      = cnt_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_if || grant_dm) begin
                    state_d   = ST_BUSY;
                    cnt_d     = LAT_LOAD;
                    owner_d   = grant_if ? OWN_IF : OWN_DM;
                    store_d   = grant_dm & dm_we;
                    hi_word_d = if_addr[2];
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = hi_word_q ? mem_rdata[63:32] : mem_rdata[31:0];
                    end else if (!store_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_IF;
            store_q    <= 1'b0;
            hi_word_q  <= 1'b0;
            cnt_q      <= 4'd0;
            starve_q   <= 4'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 64'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            store_q    <= store_d;
            hi_word_q  <= hi_word_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    // Memory command is driven only in the grant cycle; otherwise the bus
    // is held at zero.
    always_comb begin
        mem_addr  = 64'd0;
        mem_wdata = 64'd0;
        if (grant_dm) begin
            mem_addr  = {dm_addr[63:3], 3'b000};
            mem_wdata = dm_wdata;
        end else if (grant_if) begin
            mem_addr  = {if_addr[63:3], 3'b000};
        end
    end

    assign if_gnt   = grant_if;
    assign dm_gnt   = grant_dm;
    assign mem_req  = grant_if | grant_dm;
    assign mem_we   = grant_dm & dm_we;
    assign if_valid = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign dm_valid = (state_q == ST_RESP) && (owner_q == OWN_DM);
    assign if_rdata = if_rdata_q;
    assign dm_rdata = dm_rdata_q;

    // Stall is forced low during reset so every output reads zero then.
    assign stall = reset & ((if_req & ~if_valid) | (dm_req & ~dm_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter. Two instances share the requester
// inputs: u_dut_a uses MEM_LATENCY=2, u_dut_b uses MEM_LATENCY=1. Each has
// its own memory model that returns read data exactly MEM_LATENCY cycles
// after mem_req and a poison pattern in every other cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [63:0] dm_addr;
    logic [63:0] dm_wdata;

    logic        if_gnt_a, if_valid_a, dm_gnt_a, dm_valid_a;
    logic        mem_req_a, mem_we_a, stall_a;
    logic [31:0] if_rdata_a;
    logic [63:0] dm_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

    logic        if_gnt_b, if_valid_b, dm_gnt_b, dm_valid_b;
    logic        mem_req_b, mem_we_b, stall_b;
    logic [31:0] if_rdata_b;
    logic [63:0] dm_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    int checks = 0;
    int passed = 0;

    localparam logic [63:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LATENCY(2), .STARVE_LIMIT(4)) u_dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a),
        .if_valid(if_valid_a), .if_rdata(if_rdata_a),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt_a), .dm_valid(dm_valid_a), .dm_rdata(dm_rdata_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a), .stall(stall_a)
    );

    mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b),
        .if_valid(if_valid_b), .if_rdata(if_rdata_b),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt_b), .dm_valid(dm_valid_b), .dm_rdata(dm_rdata_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .stall(stall_b)
    );

    // Power-on memory image: doubleword 0x100 holds an instruction pair,
    // everything else reads zero until written.
    function automatic logic [63:0] rom_init(input logic [5:0] idx);
        return (idx == 6'd32) ? 64'hDEADBEEF_00500093 : 64'd0;
    endfunction

    // Memory model for the latency-2 instance.
    logic [63:0] data_a [0:63];
    logic        wr_a   [0:63] = '{default: 1'b0};
    logic [63:0] rd_a   [0:1];
    logic        rv_a   [0:1]  = '{default: 1'b0};

    always @(posedge clk) begin
        rv_a[0] <= mem_req_a && !mem_we_a;
        rd_a[0] <= wr_a[mem_addr_a[8:3]] ? data_a[mem_addr_a[8:3]] : rom_init(mem_addr_a[8:3]);
        rv_a[1] <= rv_a[0];
        rd_a[1] <= rd_a[0];
        if (mem_req_a && mem_we_a) begin
            data_a[mem_addr_a[8:3]] <= mem_wdata_a;
            wr_a[mem_addr_a[8:3]]   <= 1'b1;
        end
    end
    assign mem_rdata_a = rv_a[1] ? rd_a[1] : POISON;

    // Memory model for the latency-1 instance.
    logic [63:0] data_b [0:63];
    logic        wr_b   [0:63] = '{default: 1'b0};
    logic [63:0] rd_b;
    logic        rv_b = 1'b0;

    always @(posedge clk) begin
        rv_b <= mem_req_b && !mem_we_b;
        rd_b <= wr_b[mem_addr_b[8:3]] ? data_b[mem_addr_b[8:3]] : rom_init(mem_addr_b[8:3]);
        if (mem_req_b && mem_we_b) begin
            data_b[mem_addr_b[8:3]] <= mem_wdata_b;
            wr_b[mem_addr_b[8:3]]   <= 1'b1;
        end
    end
    assign mem_rdata_b = rv_b ? rd_b : POISON;

    // Leaves the caller at the negedge on which reset was released.
    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b0;
        if_req   = 1'b0;
        if_addr  = 64'd0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 64'd0;
        dm_wdata = 64'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        @(negedge clk);
        reset   = 1'b0;
        if_req  = 1'b1;
        if_addr = 64'h104;
        dm_req  = 1'b0;
        #1;
        checks++;
        if ({if_gnt_a, dm_gnt_a, if_valid_a, dm_valid_a, mem_req_a, mem_we_a, stall_a} !== 7'b0)
            $display("[TB] FAIL reset_ctrl: got %b want 0000000",
                     {if_gnt_a, dm_gnt_a, if_valid_a, dm_valid_a, mem_req_a, mem_we_a, stall_a});
        else passed++;
        checks++;
        if ({mem_addr_a, mem_wdata_a, dm_rdata_a, if_rdata_a} !== 224'd0)
            $display("[TB] FAIL reset_data: got %h want 0",
                     {mem_addr_a, mem_wdata_a, dm_rdata_a, if_rdata_a});
        else passed++;

        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({if_gnt_a, mem_req_a, mem_addr_a} !== {1'b1, 1'b1, 64'h100})
            $display("[TB] FAIL reset_pre_grant: got %b %b %h want 1 1 100", if_gnt_a, mem_req_a, mem_addr_a);
        else passed++;

        @(negedge clk);
        #1;
        checks++;
        if ({mem_req_a, stall_a} !== 2'b01)
            $display("[TB] FAIL reset_pre_busy: got %b want 01", {mem_req_a, stall_a});
        else passed++;

        reset = 1'b0;
        #1;
        checks++;
        if ({if_gnt_a, if_valid_a, mem_req_a, stall_a, mem_addr_a, if_rdata_a} !== 100'd0)
            $display("[TB] FAIL reset_mid_busy: got %h want 0",
                     {if_gnt_a, if_valid_a, mem_req_a, stall_a, mem_addr_a, if_rdata_a});
        else passed++;

        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            checks++;
            if ({mem_req_a, if_valid_a, dm_valid_a, stall_a} !== 4'b0)
                $display("[TB] FAIL reset_after_c%0d: got %b want 0000", c,
                         {mem_req_a, if_valid_a, dm_valid_a, stall_a});
            else passed++;
        end

        if_req  = 1'b1;
        if_addr = 64'h100;
        #1;
        checks++;
        if (if_gnt_a !== 1'b1)
            $display("[TB] FAIL reset_idle_grant: got %b want 1", if_gnt_a);
        else passed++;
        if_req = 1'b0;
    endtask

    task automatic test_fetch();
        $display("[TB] test_fetch");
        do_reset();
        if_req  = 1'b1;
        if_addr = 64'h104;
        #1;
        checks++;
        if ({if_gnt_a, dm_gnt_a, mem_req_a, mem_we_a, stall_a, mem_addr_a, mem_wdata_a} !==
            {5'b10101, 64'h100, 64'h0})
            $display("[TB] FAIL fetch_grant: got %b %h %h want 10101 100 0",
                     {if_gnt_a, dm_gnt_a, mem_req_a, mem_we_a, stall_a}, mem_addr_a, mem_wdata_a);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({if_gnt_a, mem_req_a, if_valid_a, stall_a} !== ((k == 3) ? 4'b0010 : 4'b0001))
                $display("[TB] FAIL fetch_t%0d: got %b want %b", k,
                         {if_gnt_a, mem_req_a, if_valid_a, stall_a}, (k == 3) ? 4'b0010 : 4'b0001);
            else passed++;
        end
        checks++;
        if (if_rdata_a !== 32'hDEADBEEF)
            $display("[TB] FAIL fetch_rdata: got %h want deadbeef", if_rdata_a);
        else passed++;

        @(negedge clk);
        if_req = 1'b0;
        #1;
        checks++;
        if ({if_valid_a, stall_a, mem_req_a, if_rdata_a} !== {3'b000, 32'hDEADBEEF})
            $display("[TB] FAIL fetch_after: got %b %h want 000 deadbeef",
                     {if_valid_a, stall_a, mem_req_a}, if_rdata_a);
        else passed++;
    endtask

    task automatic test_store_load();
        $display("[TB] test_store_load");
        do_reset();
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 64'h20;
        dm_wdata = 64'h1122334455667788;
        #1;
        checks++;
        if ({dm_gnt_a, if_gnt_a, mem_req_a, mem_we_a, mem_addr_a, mem_wdata_a} !==
            {4'b1011, 64'h20, 64'h1122334455667788})
            $display("[TB] FAIL store_grant: got %b %h %h want 1011 20 1122334455667788",
                     {dm_gnt_a, if_gnt_a, mem_req_a, mem_we_a}, mem_addr_a, mem_wdata_a);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({dm_gnt_a, mem_req_a, dm_valid_a, stall_a} !== ((k == 3) ? 4'b0010 : 4'b0001))
                $display("[TB] FAIL store_t%0d: got %b want %b", k,
                         {dm_gnt_a, mem_req_a, dm_valid_a, stall_a}, (k == 3) ? 4'b0010 : 4'b0001);
            else passed++;
        end
        checks++;
        if (dm_rdata_a !== 64'd0)
            $display("[TB] FAIL store_rdata_kept: got %h want 0", dm_rdata_a);
        else passed++;

        dm_we   = 1'b0;
        dm_addr = 64'h25;
        @(negedge clk);
        #1;
        checks++;
        if ({dm_gnt_a, mem_req_a, mem_we_a, mem_addr_a} !== {3'b110, 64'h20})
            $display("[TB] FAIL load_grant: got %b %h want 110 20",
                     {dm_gnt_a, mem_req_a, mem_we_a}, mem_addr_a);
        else passed++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({dm_gnt_a, mem_req_a, dm_valid_a, stall_a} !== ((k == 3) ? 4'b0010 : 4'b0001))
                $display("[TB] FAIL load_t%0d: got %b want %b", k,
                         {dm_gnt_a, mem_req_a, dm_valid_a, stall_a}, (k == 3) ? 4'b0010 : 4'b0001);
            else passed++;
        end
        checks++;
        if (dm_rdata_a !== 64'h1122334455667788)
            $display("[TB] FAIL load_rdata: got %h want 1122334455667788", dm_rdata_a);
        else passed++;

        @(negedge clk);
        dm_req = 1'b0;
        #1;
        checks++;
        if ({dm_gnt_a, mem_req_a, stall_a, dm_valid_a} !== 4'b0)
            $display("[TB] FAIL load_after: got %b want 0000", {dm_gnt_a, mem_req_a, stall_a, dm_valid_a});
        else passed++;
    endtask

    task automatic test_simultaneous();
        int dm_first = -1;
        int if_first = -1;
        int both     = 0;
        $display("[TB] test_simultaneous");
        do_reset();
        if_req  = 1'b1;
        if_addr = 64'h100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 64'h20;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (dm_gnt_a && if_gnt_a) both++;
            if (dm_gnt_a && (dm_first < 0)) dm_first = c;
            if (if_gnt_a && (if_first < 0)) if_first = c;
            if (dm_valid_a) dm_req = 1'b0;
            if (if_valid_a) if_req = 1'b0;
        end
        checks++;
        if (dm_first !== 0)
            $display("[TB] FAIL simul_dm_first: got %0d want 0", dm_first);
        else passed++;
        checks++;
        if (if_first !== 4)
            $display("[TB] FAIL simul_if_first: got %0d want 4", if_first);
        else passed++;
        checks++;
        if (both !== 0)
            $display("[TB] FAIL simul_both_gnt: got %0d want 0", both);
        else passed++;
    endtask

    task automatic test_starvation();
        int         n = 0;
        logic [5:0] order = 6'd0;
        $display("[TB] test_starvation");
        do_reset();
        if_req  = 1'b1;
        if_addr = 64'h100;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 64'h20;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (n < 6) begin
                if (if_gnt_a) begin
                    order[n] = 1'b1;
                    n++;
                end else if (dm_gnt_a) begin
                    order[n] = 1'b0;
                    n++;
                end
            end
        end
        checks++;
        if (n !== 6)
            $display("[TB] FAIL starve_count: got %0d grants want 6", n);
        else passed++;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (order[i] !== (i == 4))
                $display("[TB] FAIL starve_grant%0d: got is_fetch=%b want %b", i, order[i], (i == 4));
            else passed++;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    task automatic test_latency1();
        int          g [4];
        int          ng     = 0;
        int          vfirst = -1;
        int          dm_any = 0;
        logic [31:0] word   = 32'd0;
        $display("[TB] test_latency1");
        do_reset();
        if_req  = 1'b1;
        if_addr = 64'h100;
        for (int c = 0; c < 11; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (if_gnt_b && (ng < 4)) begin
                g[ng] = c;
                ng++;
            end
            if (if_valid_b && (vfirst < 0)) begin
                vfirst = c;
                word   = if_rdata_b;
            end
            if (dm_gnt_b || dm_valid_b) dm_any++;
        end
        if_req = 1'b0;
        checks++;
        if (ng !== 4)
            $display("[TB] FAIL lat1_grants: got %0d want 4", ng);
        else passed++;
        checks++;
        if ({g[0], g[1], g[2], g[3]} !== {32'd0, 32'd3, 32'd6, 32'd9})
            $display("[TB] FAIL lat1_spacing: got %0d %0d %0d %0d want 0 3 6 9", g[0], g[1], g[2], g[3]);
        else passed++;
        checks++;
        if (vfirst !== 2)
            $display("[TB] FAIL lat1_valid: got %0d want 2", vfirst);
        else passed++;
        checks++;
        if (word !== 32'h00500093)
            $display("[TB] FAIL lat1_rdata: got %h want 00500093", word);
        else passed++;
        checks++;
        if (dm_any !== 0)
            $display("[TB] FAIL lat1_no_dm: got %0d want 0", dm_any);
        else passed++;
    endtask

    initial begin
        reset    = 1'b0;
        if_req   = 1'b0;
        if_addr  = 64'd0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 64'd0;
        dm_wdata = 64'd0;
        test_reset();
        test_fetch();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_latency1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 64-bit unified memory between the processor's instruction-fetch path and its load/store path.
- Runs a fixed-latency memory transaction sequencer and arbitrates between the two requesters.
- Drives a stall output so the processor core freezes PC and pipeline registers while an access is outstanding.
- Sits between the core (PC/instruction path, data-memory path) and the memory model.

Parameters:
- MEM_LATENCY, 2: cycles from mem_req issue to valid mem_rdata; legal range 1..15.
- STARVE_LIMIT, 4: number of consecutive data grants, taken while if_req is pending, after which fetch is forced to win the next arbitration; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- if_req  in  1  fetch request (level); if_addr held stable until if_valid.
- if_addr  in  64  fetch byte address.
- if_gnt  out  1  one-cycle pulse: fetch won arbitration.
- if_valid  out  1  one-cycle pulse: if_rdata holds the instruction.
- if_rdata  out  32  fetched instruction word.
- dm_req  in  1  data request (level); dm_addr, dm_we and dm_wdata held stable until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  64  data byte address.
- dm_wdata  in  64  store data.
- dm_gnt  out  1  one-cycle pulse: data port won arbitration.
- dm_valid  out  1  one-cycle pulse: access complete; dm_rdata holds the load data.
- dm_rdata  out  64  load data.
- mem_req  out  1  one-cycle memory command strobe.
- mem_we  out  1  memory write enable, qualified by mem_req.
- mem_addr  out  64  doubleword address; bits [2:0] forced to 0.
- mem_wdata  out  64  memory write data.
- mem_rdata  in  64  memory read data, valid exactly MEM_LATENCY cycles after mem_req.
- stall  out  1  core hold.

Behaviour:
- Reset (asynchronous, reset=0):
  - State IDLE; latency counter and starvation counter cleared.
  - All outputs 0, including the if_rdata and dm_rdata registers.
  - Reset during BUSY or RESP aborts the access; the pending memory response is ignored and no valid pulse is issued.
- FSM states: IDLE, BUSY, RESP. An owner register (IF or DM) is captured at grant.
- IDLE:
  - If any request is present, grant exactly one requester.
  - In the grant cycle, mem_req=1, the matching x_gnt=1, and mem_addr/mem_we/mem_wdata are driven from the winner.
  - Load counter with MEM_LATENCY-1; go to BUSY.
  - Fetch grants drive mem_we=0 and mem_wdata=0.
- Arbitration:
  - dm_req wins by default.
  - if_req wins when dm_req=0, or when starve_cnt==STARVE_LIMIT and if_req=1.
- Starvation counter:
  - starve_cnt increments, saturating, on each dm grant made while if_req=1.
  - It clears on any if grant, and in any cycle where if_req=0.
- BUSY:
  - The counter decrements each cycle; no outputs are asserted except stall.
  - In the cycle the counter reaches 0 (the cycle mem_rdata is valid), capture mem_rdata and go to RESP.
  - For the owner:
    - IF: if_rdata = captured[31:0] when if_addr[2]=0, else captured[63:32].
    - DM read: dm_rdata = captured.
    - DM write: dm_rdata is left unchanged.
- RESP: one cycle. The owner's x_valid=1, no grant is made in this cycle, then go to IDLE.
- Latency: grant in cycle T, x_valid in cycle T+MEM_LATENCY+1, earliest next grant T+MEM_LATENCY+2.
- Stall: stall = (if_req & ~if_valid) | (dm_req & ~dm_valid), purely combinational.
- Requester behaviour:
  - A requester that drops its req mid-transaction still receives its valid pulse; the core ignores it.
  - Requests are not queued beyond the level req inputs.
- Addressing: low 3 address bits never reach memory. Loads and stores are full doubleword; sub-word handling belongs to the core.

Test Plan:
- Reset: reset=0 mid-BUSY with MEM_LATENCY=2 -> all outputs 0 immediately, state IDLE; after release with no requests, mem_req stays 0 and stall=0.
- Fetch only: if_req=1, if_addr=0x104, memory word at 0x100 = 0xDEADBEEF_00500093 -> if_gnt at T, mem_addr=0x100, if_valid at T+3, if_rdata=0xDEADBEEF; stall=1 for cycles T..T+2.
- Store then load: dm_we=1, dm_addr=0x20, dm_wdata=0x1122334455667788, then dm_we=0 load from 0x20 -> dm_valid pulses at T+3 and T+7; load dm_rdata=0x1122334455667788.
- Simultaneous requests: if_req=dm_req=1 in the same cycle -> dm_gnt first, if_gnt 4 cycles later; no cycle has both gnt outputs high.
- Starvation: dm_req held high, if_req held high, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM...
- MEM_LATENCY=1: fetch -> if_valid at T+2; back-to-back fetches granted every 3 cycles.
